// File: rtl/frame_tx_pkg.sv
// Shared types and constants for the frame UART transmitter.
// Header bytes are only used when FRAME_TX_HEADER_EN is defined.
package frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } frame_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_START,
    PH_DATA,
    PH_STOP
  } bit_phase_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int unsigned DATA_BITS = 8;

  localparam logic [7:0] HDR0 = 8'hA5;
  localparam logic [7:0] HDR1 = 8'h5A;
  localparam int unsigned HDR_BYTES = 2;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: bit timer plus LSB-first shifter.
// byte_done is high on the last cycle of the stop bit.
import frame_tx_pkg::*;

module uart_byte_tx #(
  parameter int unsigned CLKS_PER_BIT = 564
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy,
  output logic       byte_done
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  bit_phase_t    phase, phase_n;
  logic [TW-1:0] timer, timer_n;
  logic [7:0]    shreg, shreg_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic          tick;

  assign tick = (timer == TMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= PH_IDLE;
      timer   <= '0;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      phase   <= phase_n;
      timer   <= timer_n;
      shreg   <= shreg_n;
      bit_idx <= bit_idx_n;
    end
  end

  // load restarts the byte from any phase, so an aborted byte never leaks out
  always_comb begin
    phase_n   = phase;
    timer_n   = timer;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    if (load) begin
      phase_n   = PH_START;
      timer_n   = '0;
      shreg_n   = data;
      bit_idx_n = '0;
    end else if (phase != PH_IDLE) begin
      timer_n = tick ? '0 : timer + 1'b1;
      if (tick) begin
        case (phase)
          PH_START: phase_n = PH_DATA;
          PH_DATA: begin
            shreg_n   = {1'b0, shreg[7:1]};
            bit_idx_n = bit_idx + 1'b1;
            if (bit_idx == 3'(DATA_BITS - 1)) phase_n = PH_STOP;
          end
          PH_STOP: phase_n = PH_IDLE;
          default: phase_n = PH_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    case (phase)
      PH_START: txd = START_BIT;
      PH_DATA:  txd = shreg[0];
      default:  txd = STOP_BIT;
    endcase
  end

  assign busy      = (phase != PH_IDLE);
  assign byte_done = (phase == PH_STOP) && tick;

endmodule

// File: rtl/frame_uart_tx.sv
// Streams a stored frame from BRAM over UART 8N1, one byte per BRAM address.
// Define FRAME_TX_HEADER_EN to prefix each frame with sync bytes 0xA5, 0x5A.
import frame_tx_pkg::*;

module frame_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 564,
  parameter int unsigned FRAME_BYTES  = 256000,
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned RD_LAT       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              frame_ready,
  input  logic              abort,
  input  logic [7:0]        bram_dout,
  output logic [ADDR_W-1:0] tx_counter,
  output logic              transmitting,
  output logic              uart_txd,
  output logic              done
);

  localparam int unsigned WW = $clog2(RD_LAT + 1);
  localparam logic [WW-1:0]     WAIT_MAX  = WW'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

  frame_state_t      state, state_n;
  logic [ADDR_W-1:0] cnt_n;
  logic              xmit_n;
  logic [WW-1:0]     wait_cnt, wait_n;
  logic              start_q, start_rise;
  logic              load;
  logic [7:0]        load_data;
  logic              byte_txd, byte_busy, byte_done;
`ifdef FRAME_TX_HEADER_EN
  logic [1:0]        hdr_cnt, hdr_n;
`endif

  assign start_rise = start & ~start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      tx_counter   <= '0;
      transmitting <= 1'b0;
      wait_cnt     <= '0;
      start_q      <= 1'b0;
`ifdef FRAME_TX_HEADER_EN
      hdr_cnt      <= '0;
`endif
    end else begin
      state        <= state_n;
      tx_counter   <= cnt_n;
      transmitting <= xmit_n;
      wait_cnt     <= wait_n;
      start_q      <= start;
`ifdef FRAME_TX_HEADER_EN
      hdr_cnt      <= hdr_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = tx_counter;
    xmit_n  = transmitting;
    wait_n  = wait_cnt;
    load    = 1'b0;
`ifdef FRAME_TX_HEADER_EN
    hdr_n   = hdr_cnt;
`endif
    // abort also wins over a start edge seen in IDLE
    if (abort) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      xmit_n  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_rise && frame_ready) begin
            state_n = ST_FETCH;
            xmit_n  = 1'b1;
            cnt_n   = '0;
            wait_n  = '0;
`ifdef FRAME_TX_HEADER_EN
            hdr_n   = '0;
`endif
          end
        end
        ST_FETCH: begin
          if (wait_cnt == WAIT_MAX) state_n = ST_LOAD;
          else                      wait_n  = wait_cnt + 1'b1;
        end
        ST_LOAD: begin
          load    = 1'b1;
          state_n = ST_SEND;
        end
        ST_SEND: begin
          if (byte_done) begin
            wait_n  = '0;
            state_n = ST_FETCH;
`ifdef FRAME_TX_HEADER_EN
            if (hdr_cnt < 2'(HDR_BYTES)) hdr_n = hdr_cnt + 1'b1;
            else
`endif
            if (tx_counter == LAST_ADDR) state_n = ST_DONE;
            else                         cnt_n   = tx_counter + 1'b1;
          end
        end
        ST_DONE: begin
          xmit_n  = 1'b0;
          cnt_n   = '0;
          state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

`ifdef FRAME_TX_HEADER_EN
  always_comb begin
    case (hdr_cnt)
      2'd0:    load_data = HDR0;
      2'd1:    load_data = HDR1;
      default: load_data = bram_dout;
    endcase
  end
`else
  assign load_data = bram_dout;
`endif

  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .data      (load_data),
    .txd       (byte_txd),
    .busy      (byte_busy),
    .byte_done (byte_done)
  );

  // Line is forced idle outside SEND so an abort mid-byte returns it high at once
  assign uart_txd = (state == ST_SEND && byte_busy) ? byte_txd : STOP_BIT;
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_frame_uart_tx.sv
// Self-checking bench for frame_uart_tx: decodes the serial line and compares
// against the frame contents held in a BRAM model.
module tb_frame_uart_tx;

  localparam int unsigned CPB = 4;
  localparam int unsigned FB  = 4;
  localparam int unsigned AW  = 18;
  localparam int unsigned RL  = 2;
  localparam int BYTE_CYC = 10 * CPB + RL + 1;
`ifdef FRAME_TX_HEADER_EN
  localparam int NHDR = 2;
`else
  localparam int NHDR = 0;
`endif
  localparam int WIN = (NHDR + FB) * BYTE_CYC + 30;

  logic          clk;
  logic          rst_n, start, frame_ready, abort;
  logic [7:0]    bram_dout;
  logic [AW-1:0] tx_counter;
  logic          transmitting, uart_txd, done;

  int total, bad;

  logic [7:0]    mem [FB];
  logic [7:0]    rd_pipe;
  logic          rec;
  logic          line_q[$];
  logic          done_q[$];
  logic          xmit_q[$];
  logic [AW-1:0] cnt_q[$];
  logic [7:0]    exp_q[$];

  frame_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FRAME_BYTES (FB),
    .ADDR_W      (AW),
    .RD_LAT      (RL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .frame_ready (frame_ready),
    .abort       (abort),
    .bram_dout   (bram_dout),
    .tx_counter  (tx_counter),
    .transmitting(transmitting),
    .uart_txd    (uart_txd),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-cycle read latency BRAM
  always @(posedge clk) begin
    rd_pipe   <= (int'(tx_counter) < FB) ? mem[int'(tx_counter)] : 8'h00;
    bram_dout <= rd_pipe;
  end

  always @(negedge clk) begin
    if (rec) begin
      line_q.push_back(uart_txd);
      done_q.push_back(done);
      xmit_q.push_back(transmitting);
      cnt_q.push_back(tx_counter);
    end
  end

  task automatic clear_rec();
    line_q.delete();
    done_q.delete();
    xmit_q.delete();
    cnt_q.delete();
  endtask

  task automatic set_ramp();
    for (int i = 0; i < FB; i++) mem[i] = 8'(8'h11 * (i + 1));
  endtask

  task automatic build_exp();
    exp_q.delete();
    if (NHDR > 0) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
    end
    for (int i = 0; i < FB; i++) exp_q.push_back(mem[i]);
  endtask

  task automatic check_stream(input string tag, input int exp_done);
    int i, n, last_end, done_at, ndone, timing_err, space_err, xmit_err, hdr_err;
    int starts[$];
    logic [7:0] got[$];
    logic [7:0] b;
    i = 0; timing_err = 0; space_err = 0; xmit_err = 0; hdr_err = 0;
    ndone = 0; done_at = -1; last_end = -1;
    while (i < line_q.size()) begin
      if (line_q[i] === 1'b0) begin
        if (i + 10 * CPB > line_q.size()) begin
          timing_err++;
          break;
        end
        for (int k = 0; k < 10; k++)
          for (int c = 0; c < CPB; c++)
            if (line_q[i + k * CPB + c] !== line_q[i + k * CPB]) timing_err++;
        if (line_q[i + 9 * CPB] !== 1'b1) timing_err++;
        b = '0;
        for (int k = 0; k < 8; k++) b[k] = line_q[i + (k + 1) * CPB];
        starts.push_back(i);
        got.push_back(b);
        i += 10 * CPB;
      end else i++;
    end

    total++;
    if (got.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL %s byte_count: got %0d expected %0d", tag, got.size(), exp_q.size());
    end
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      total++;
      if (got[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL %s byte[%0d]: got %02h expected %02h", tag, k, got[k], exp_q[k]);
      end
    end
    total++;
    if (timing_err != 0) begin
      bad++;
      $display("FAIL %s bit_timing: got %0d bad samples expected 0", tag, timing_err);
    end
    for (int k = 1; k < starts.size(); k++)
      if (starts[k] - starts[k-1] != BYTE_CYC) space_err++;
    total++;
    if (space_err != 0) begin
      bad++;
      $display("FAIL %s byte_period: got %0d wrong gaps expected 0", tag, space_err);
    end

    for (int k = 0; k < done_q.size(); k++)
      if (done_q[k] === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
    total++;
    if (ndone !== exp_done) begin
      bad++;
      $display("FAIL %s done_count: got %0d expected %0d", tag, ndone, exp_done);
    end
    if (starts.size() > 0) last_end = starts[starts.size()-1] + 10 * CPB - 1;
    total++;
    if (done_at !== last_end + 1) begin
      bad++;
      $display("FAIL %s done_position: got %0d expected %0d", tag, done_at, last_end + 1);
    end
    if (starts.size() > 0)
      for (int k = starts[0]; k <= last_end; k++)
        if (xmit_q[k] !== 1'b1) xmit_err++;
    total++;
    if (xmit_err != 0) begin
      bad++;
      $display("FAIL %s transmitting_held: got %0d low samples expected 0", tag, xmit_err);
    end
    total++;
    if (xmit_q[xmit_q.size()-1] !== 1'b0 || cnt_q[cnt_q.size()-1] !== '0) begin
      bad++;
      $display("FAIL %s end_state: got xmit=%b cnt=%0d expected xmit=0 cnt=0", tag,
               xmit_q[xmit_q.size()-1], cnt_q[cnt_q.size()-1]);
    end
    if (NHDR > 0 && starts.size() > NHDR) begin
      for (int k = 0; k < starts[NHDR]; k++)
        if (cnt_q[k] !== '0) hdr_err++;
      total++;
      if (hdr_err != 0) begin
        bad++;
        $display("FAIL %s hdr_addr: got %0d nonzero addr samples expected 0", tag, hdr_err);
      end
    end
  endtask

  // p1/p2: extra start pulses (cycle offsets), drop_at: frame_ready falls, slen: start length
  task automatic run_frame(input string tag, input int p1, input int p2, input int drop_at,
                           input int slen);
    build_exp();
    clear_rec();
    rec = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < WIN; c++) begin
      @(negedge clk);
      start = (c < slen - 1) || (c == p1) || (c == p2);
      if (c == drop_at) frame_ready = 1'b0;
    end
    start = 1'b0;
    frame_ready = 1'b1;
    rec = 1'b0;
    check_stream(tag, 1);
  endtask

  task automatic wait_byte_start(input string tag, input logic [AW-1:0] addr, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (tx_counter === addr && uart_txd === 1'b0) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s wait_timeout: got no start bit at addr %0d expected one", tag, addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; frame_ready = 1'b1; abort = 1'b0; rec = 1'b0;
    #1;
    total++;
    if (uart_txd !== 1'b1 || transmitting !== 1'b0 || tx_counter !== '0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: got txd=%b xmit=%b cnt=%0d done=%b expected 1 0 0 0",
               uart_txd, transmitting, tx_counter, done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (uart_txd !== 1'b1 || transmitting !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got txd=%b xmit=%b expected 1 0", uart_txd, transmitting);
    end
  endtask

  task automatic test_frame();
    set_ramp();
    run_frame("ramp", -1, -1, -1, 1);
  endtask

  task automatic test_no_frame_ready();
    int act;
    act = 0;
    frame_ready = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || transmitting !== 1'b0) act++;
    end
    frame_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || transmitting !== 1'b0) act++;
    end
    total++;
    if (act != 0) begin
      bad++;
      $display("FAIL no_frame_ready: got %0d active samples expected 0", act);
    end
  endtask

  task automatic test_back_to_back();
    int lim, p1, p2;
    lim = (NHDR + FB) * BYTE_CYC - 10;
    p1 = $urandom_range(10, lim / 2);
    p2 = $urandom_range(lim / 2 + 2, lim);
    set_ramp();
    run_frame("second_start", p1, p2, -1, 1);
  endtask

  task automatic test_abort();
    bit ok;
    int quiet;
    set_ramp();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_byte_start("abort", AW'(2), ok);
    repeat (CPB + $urandom_range(0, 8 * CPB - 1)) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (uart_txd !== 1'b1 || transmitting !== 1'b0 || tx_counter !== '0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_next: got txd=%b xmit=%b cnt=%0d done=%b expected 1 0 0 0",
               uart_txd, transmitting, tx_counter, done);
    end
    quiet = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || transmitting !== 1'b0 || done !== 1'b0) quiet++;
    end
    total++;
    if (quiet != 0) begin
      bad++;
      $display("FAIL abort_quiet: got %0d active samples expected 0", quiet);
    end
    run_frame("after_abort", -1, -1, -1, 1);
  endtask

  task automatic test_abort_start_idle();
    int act;
    act = 0;
    @(negedge clk); abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || transmitting !== 1'b0) act++;
    end
    start = 1'b0;
    total++;
    if (act != 0) begin
      bad++;
      $display("FAIL abort_start_idle: got %0d active samples expected 0", act);
    end
  endtask

  task automatic test_random_frames();
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < FB; i++) mem[i] = 8'($urandom);
      run_frame($sformatf("random%0d", it), -1, -1,
                $urandom_range(5, (NHDR + FB) * BYTE_CYC - 20), $urandom_range(1, 4));
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_ramp();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_byte_start("reset_mid", AW'(1), ok);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (uart_txd !== 1'b1 || transmitting !== 1'b0 || tx_counter !== '0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_async: got txd=%b xmit=%b cnt=%0d done=%b expected 1 0 0 0",
               uart_txd, transmitting, tx_counter, done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (uart_txd !== 1'b1 || transmitting !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_release: got txd=%b xmit=%b expected 1 0", uart_txd, transmitting);
    end
    run_frame("after_reset", -1, -1, -1, 2);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_frame();
    test_no_frame_ready();
    test_back_to_back();
    test_abort();
    test_abort_start_idle();
    test_random_frames();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
